bz_sfx_arbiter: RTL
===================

Name: bz_sfx_arbiter

Overview:
Shares the single buzzer tone-PWM resource between the background music sequencer and NUM_SFX game sound effects (jump, coin, crash). Effects use fixed priority and pre-empt music. While an effect plays, the block freezes the music sequencer so music resumes exactly where it stopped. It sits between the music controller/address/beat logic and the tone PWM, and drives the PWM's divisor, enable and restart.

Parameters:
NUM_SFX, 3, number of effect requesters; index 0 has the highest priority.
DIV_W, 18, tone divisor width in clk cycles per half-period.
DUR_W, 24, effect duration width in clk cycles.
GAP_CYC, 4, silent cycles inserted after each effect before the next source plays.

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
music_en  in  1  music playback enabled
music_div  in  DIV_W  current music note divisor; 0 means rest
music_hold  out  1  1 = freeze the music sequencer (gates its beat counter)
sfx_req  in  NUM_SFX  one-cycle request pulses
sfx_div  in  NUM_SFX*DIV_W  per-effect tone divisor, packed with index 0 in the LSBs
sfx_dur  in  NUM_SFX*DUR_W  per-effect duration, packed the same way
sfx_grant  out  NUM_SFX  one-hot active effect; 0 when no effect is active
sfx_busy  out  1  effect load, play or gap in progress
tone_div  out  DIV_W  divisor to the tone PWM
tone_en  out  1  tone PWM enable
tone_rstn  out  1  tone PWM synchronous restart, active low
src  out  2  0 = idle, 1 = music, 2 = sfx, 3 = gap

Behaviour:
- Clock and reset: one clock (clk); reset (rstn) is asynchronous and active-low.
- Reset values: state IDLE; pending=0; all outputs 0 (tone_rstn=0, so the PWM is held in restart).
- All outputs are registered and derive from the next state and its data, so they are valid in the same cycle the state is entered.
- Pending latch, per effect:
  - set on sfx_req[i]; cleared on the cycle the effect is granted (SFX_LOAD);
  - if set and clear coincide, set wins;
  - a request during its own play sets pending again, so the effect replays after the gap.
- Selection: the lowest-index pending bit wins.
- IDLE:
  - any pending -> SFX_LOAD;
  - else music_en -> MUSIC;
  - outputs: tone_en=0, music_hold=0, tone_rstn=0, src=0.
- MUSIC:
  - tone_div=music_div; tone_en=(music_div!=0); music_hold=0; tone_rstn=1; src=1;
  - on entry, tone_rstn=0 for the first cycle only;
  - any pending -> SFX_LOAD (pending has priority over music_en deassertion);
  - else !music_en -> IDLE.
- SFX_LOAD (1 cycle):
  - latch the winner's div and duration; a duration of 0 is loaded as 1;
  - sfx_grant = one-hot winner; tone_rstn=0; tone_en=0; music_hold=1; sfx_busy=1; src=2;
  - -> SFX_PLAY.
- SFX_PLAY:
  - tone_en=1; tone_div=latched div; the down-counter decrements every cycle;
  - when count==1 -> GAP, giving exactly dur cycles with tone_en=1;
  - pre-emption: a pending bit with strictly higher priority than the active grant -> SFX_LOAD immediately, with no gap; the pre-empted effect is dropped, not resumed;
  - equal- or lower-priority pending bits wait.
- GAP:
  - GAP_CYC cycles; tone_en=0; music_hold=1; sfx_grant=0; sfx_busy=1; src=3;
  - then: pending -> SFX_LOAD; else music_en -> MUSIC; else -> IDLE.
- Latency: req at edge t -> pending at t+1 -> SFX_LOAD at t+2 -> tone_en=1 from t+3.
- music_div changes during an effect are ignored; tone_div follows music_div live only in MUSIC.
- music_hold is 1 in SFX_LOAD, SFX_PLAY and GAP, and goes to 0 in the same cycle MUSIC or IDLE is entered.
- Reset mid-effect: all state cleared at once; pending requests are lost.

Decomposition:
- Shared package bz_pkg:
  - state enum (IDLE, MUSIC, SFX_LOAD, SFX_PLAY, GAP);
  - SRC_* codes;
  - default DIV_W and DUR_W.
- Sub-module bz_sfx_pending: pending latches plus fixed-priority encoder. Outputs: winner one-hot, any_pending, and higher_than(active grant).

Test Plan:
- NUM_SFX=3, GAP_CYC=4, music_en=1, music_div=1000, no requests -> src=1 and tone_div=1000 from the second cycle after reset release; tone_rstn low exactly one cycle on MUSIC entry; music_hold=0.
- Pulse sfx_req[1] with div=500, dur=10 -> SFX_LOAD 2 cycles later; then 10 cycles of tone_en=1 with tone_div=500; then 4 gap cycles; then music_div=1000 resumes. music_hold=1 for exactly 15 cycles; sfx_grant=3'b010 during load and play.
- sfx_req[2] (dur=20), then sfx_req[0] (div=300, dur=5) at play cycle 6 -> SFX_LOAD for effect 0 with no gap; 5 cycles at 300; gap; music. Effect 2 is not replayed.
- sfx_req[0] and sfx_req[2] in the same cycle -> effect 0 plays, gap, effect 2 plays, gap, music.
- sfx_dur=0 on effect 1 -> tone_en=1 for exactly 1 cycle. Separately, deassert music_en during an effect -> IDLE after the gap, tone_en=0.
- Assert rstn low during SFX_PLAY -> all outputs 0 immediately; after release, no replay of the interrupted or pending effects.

Source files
------------

// File: rtl/bz_pkg.sv
// Shared types and constants for the buzzer sound-effect arbiter.
package bz_pkg;

    localparam int DIV_W_DEF = 18;
    localparam int DUR_W_DEF = 24;

    typedef enum logic [2:0] {
        IDLE,
        MUSIC,
        SFX_LOAD,
        SFX_PLAY,
        GAP
    } state_t;

    localparam logic [1:0] SRC_IDLE  = 2'd0;
    localparam logic [1:0] SRC_MUSIC = 2'd1;
    localparam logic [1:0] SRC_SFX   = 2'd2;
    localparam logic [1:0] SRC_GAP   = 2'd3;

endpackage

// File: rtl/bz_sfx_arbiter_if.sv
// Bus between the music/effect sources, the arbiter and the tone PWM.
interface bz_sfx_arbiter_if import bz_pkg::*; #(
    parameter int NUM_SFX = 3,
    parameter int DIV_W   = DIV_W_DEF,
    parameter int DUR_W   = DUR_W_DEF
);
    logic                     music_en;
    logic [DIV_W-1:0]         music_div;
    logic                     music_hold;
    logic [NUM_SFX-1:0]       sfx_req;
    logic [NUM_SFX*DIV_W-1:0] sfx_div;
    logic [NUM_SFX*DUR_W-1:0] sfx_dur;
    logic [NUM_SFX-1:0]       sfx_grant;
    logic                     sfx_busy;
    logic [DIV_W-1:0]         tone_div;
    logic                     tone_en;
    logic                     tone_rstn;
    logic [1:0]               src;

    modport slave (
        input  music_en, music_div, sfx_req, sfx_div, sfx_dur,
        output music_hold, sfx_grant, sfx_busy, tone_div, tone_en, tone_rstn, src
    );

    modport master (
        output music_en, music_div, sfx_req, sfx_div, sfx_dur,
        input  music_hold, sfx_grant, sfx_busy, tone_div, tone_en, tone_rstn, src
    );
endinterface

// File: rtl/bz_sfx_pending.sv
// Per-effect pending latches with a fixed-priority (lowest index) encoder.
module bz_sfx_pending import bz_pkg::*; #(
    parameter int NUM_SFX = 3
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NUM_SFX-1:0] sfx_req,
    input  logic [NUM_SFX-1:0] clr,
    input  logic [NUM_SFX-1:0] grant,
    output logic [NUM_SFX-1:0] winner,
    output logic               any_pending,
    output logic               higher_than
);
    logic [NUM_SFX-1:0] pending_q, pending_d;

    // A request coinciding with its own grant survives, so the effect replays.
    always_comb begin
        pending_d   = (pending_q & ~clr) | sfx_req;
        winner      = pending_q & (~pending_q + NUM_SFX'(1));
        any_pending = |pending_q;
        higher_than = (grant != '0) && ((pending_q & (grant - NUM_SFX'(1))) != '0);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) pending_q <= '0;
        else       pending_q <= pending_d;
    end
endmodule

// File: rtl/bz_sfx_arbiter.sv
// Buzzer arbiter: fixed-priority sound effects pre-empt and freeze background music.
// state    | meaning
// IDLE     | PWM held in restart, nothing playing
// MUSIC    | tone follows music_div live
// SFX_LOAD | one cycle: latch winner divisor/duration, restart PWM
// SFX_PLAY | effect tone for its duration, higher priority pre-empts
// GAP      | GAP_CYC silent cycles before the next source
module bz_sfx_arbiter import bz_pkg::*; #(
    parameter int NUM_SFX = 3,
    parameter int DIV_W   = DIV_W_DEF,
    parameter int DUR_W   = DUR_W_DEF,
    parameter int GAP_CYC = 4
) (
    input logic                clk,
    input logic                rstn,
    bz_sfx_arbiter_if.slave    bus
);
    state_t             state_q, state_d;
    logic [DUR_W-1:0]   cnt_q, cnt_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [NUM_SFX-1:0] grant_q, grant_d;
    logic [DIV_W-1:0]   tone_div_q, tone_div_d;
    logic               tone_en_q, tone_en_d;
    logic               tone_rstn_q, tone_rstn_d;
    logic               hold_q, hold_d;
    logic               busy_q, busy_d;
    logic [1:0]         src_q, src_d;

    logic [NUM_SFX-1:0] winner, clr;
    logic               any_pending, higher_than;
    logic [DIV_W-1:0]   win_div;
    logic [DUR_W-1:0]   win_dur;

    bz_sfx_pending #(.NUM_SFX(NUM_SFX)) u_pending (
        .clk         (clk),
        .rstn        (rstn),
        .sfx_req     (bus.sfx_req),
        .clr         (clr),
        .grant       (grant_q),
        .winner      (winner),
        .any_pending (any_pending),
        .higher_than (higher_than)
    );

    always_comb begin
        win_div = '0;
        win_dur = '0;
        for (int i = 0; i < NUM_SFX; i++) begin
            if (winner[i]) begin
                win_div = bus.sfx_div[i*DIV_W +: DIV_W];
                win_dur = bus.sfx_dur[i*DUR_W +: DUR_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        case (state_q)
            IDLE: begin
                if (any_pending)       state_d = SFX_LOAD;
                else if (bus.music_en) state_d = MUSIC;
            end
            MUSIC: begin
                if (any_pending)        state_d = SFX_LOAD;
                else if (!bus.music_en) state_d = IDLE;
            end
            SFX_LOAD: state_d = SFX_PLAY;
            SFX_PLAY: begin
                if (higher_than) begin
                    state_d = SFX_LOAD;
                end else if (cnt_q == DUR_W'(1)) begin
                    state_d = GAP;
                    cnt_d   = DUR_W'(GAP_CYC);
                end else begin
                    cnt_d = cnt_q - DUR_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == DUR_W'(1)) begin
                    if (any_pending)       state_d = SFX_LOAD;
                    else if (bus.music_en) state_d = MUSIC;
                    else                   state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - DUR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are computed from the state being entered.
        clr         = '0;
        grant_d     = '0;
        tone_div_d  = '0;
        tone_en_d   = 1'b0;
        tone_rstn_d = 1'b0;
        hold_d      = 1'b0;
        busy_d      = 1'b0;
        src_d       = SRC_IDLE;
        case (state_d)
            MUSIC: begin
                tone_div_d  = bus.music_div;
                tone_en_d   = (bus.music_div != '0);
                tone_rstn_d = (state_q == MUSIC);
                src_d       = SRC_MUSIC;
            end
            SFX_LOAD: begin
                clr        = winner;
                grant_d    = winner;
                div_d      = win_div;
                cnt_d      = (win_dur == '0) ? DUR_W'(1) : win_dur;
                tone_div_d = win_div;
                hold_d     = 1'b1;
                busy_d     = 1'b1;
                src_d      = SRC_SFX;
            end
            SFX_PLAY: begin
                grant_d     = grant_q;
                tone_div_d  = div_q;
                tone_en_d   = 1'b1;
                tone_rstn_d = 1'b1;
                hold_d      = 1'b1;
                busy_d      = 1'b1;
                src_d       = SRC_SFX;
            end
            GAP: begin
                tone_rstn_d = 1'b1;
                hold_d      = 1'b1;
                busy_d      = 1'b1;
                src_d       = SRC_GAP;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            div_q       <= '0;
            grant_q     <= '0;
            tone_div_q  <= '0;
            tone_en_q   <= 1'b0;
            tone_rstn_q <= 1'b0;
            hold_q      <= 1'b0;
            busy_q      <= 1'b0;
            src_q       <= SRC_IDLE;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            grant_q     <= grant_d;
            tone_div_q  <= tone_div_d;
            tone_en_q   <= tone_en_d;
            tone_rstn_q <= tone_rstn_d;
            hold_q      <= hold_d;
            busy_q      <= busy_d;
            src_q       <= src_d;
        end
    end

    assign bus.sfx_grant  = grant_q;
    assign bus.tone_div   = tone_div_q;
    assign bus.tone_en    = tone_en_q;
    assign bus.tone_rstn  = tone_rstn_q;
    assign bus.music_hold = hold_q;
    assign bus.sfx_busy   = busy_q;
    assign bus.src        = src_q;
endmodule
